// File: rtl/projection_hist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : projection_hist_pkg                                         |
// | Brief  : Shared state encoding, index-width helper and saturating    |
// |          adder for the projection histogram block.                   |
// | Rev    : 1.0  initial parametrised release                           |
// +----------------------------------------------------------------------+
package projection_hist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_DONE   = 3'd2,
      ST_READ_X = 3'd3,
      ST_READ_Y = 3'd4
   } state_t;

   localparam int DEF_IMG_W = 240;
   localparam int DEF_IMG_H = 180;

   // Index width for n entries; never narrower than one bit.
   function automatic int idx_bits(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Default index widths for the 240x180 configuration.
   localparam int XI_W  = idx_bits(DEF_IMG_W);
   localparam int YI_W  = idx_bits(DEF_IMG_H);
   localparam int IDX_W = idx_bits((DEF_IMG_W > DEF_IMG_H) ? DEF_IMG_W : DEF_IMG_H);

   // a + b clamped to 2^w-1 (w <= 32); callers cast the result to w bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] s;
      logic [32:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << w) - 33'd1;
      return (s > m) ? m[31:0] : s[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/projection_histogram_bin_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : proj_bin_array                                              |
// | Brief  : Register-file of histogram bins with synchronous clear,     |
// |          direct write, saturating increment and async read port.     |
// | Rev    : 1.0  initial parametrised release                           |
// +----------------------------------------------------------------------+
module proj_bin_array
   import projection_hist_pkg::*;
#(
   parameter int DEPTH = 240,
   parameter int BIN_W = 8,
   parameter int AW    = idx_bits(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             wr_en,
   input  logic             inc_en,
   input  logic             inc_val,
   input  logic [AW-1:0]    addr,
   input  logic [BIN_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [BIN_W-1:0] rd_data
);

   logic [BIN_W-1:0] mem [DEPTH];

   // Clear wins over write; write wins over increment.
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[addr] <= wr_data;
      end else if (inc_en) begin
         mem[addr] <= BIN_W'(sat_add(32'(mem[addr]), 32'(inc_val), BIN_W));
      end
   end

   // Addresses past the last bin read as zero.
   assign rd_data = (32'(rd_addr) < 32'(DEPTH)) ? mem[rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/projection_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : projection_histogram                                        |
// | Brief  : Column/row projection histograms of a column-major binary   |
// |          image, wake threshold on the foreground total, and          |
// |          valid/ready readout of both histograms.                     |
// | Option : PROJ_HIST_PEAK_EN adds argmax tracking of x and y bins.     |
// | Rev    : 1.0  initial parametrised release                           |
// +----------------------------------------------------------------------+
module projection_histogram
   import projection_hist_pkg::*;
#(
   parameter  int IMG_W = 240,
   parameter  int IMG_H = 180,
   parameter  int BIN_W = 8,
   parameter  int TOT_W = 16,
   localparam int XI_W  = idx_bits(IMG_W),
   localparam int YI_W  = idx_bits(IMG_H),
   localparam int IDX_W = idx_bits((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frameStart,
   input  logic             pixValid,
   input  logic             pixData,
   input  logic [TOT_W-1:0] threshold,
   input  logic             readStart,
   input  logic             readReady,
   output logic             wakeUp,
   output logic             fullImageDone,
   output logic             xValid,
   output logic             yValid,
   output logic [BIN_W-1:0] binOut,
   output logic [IDX_W-1:0] binIndex,
   output logic             busy
`ifdef PROJ_HIST_PEAK_EN
   ,
   output logic [XI_W-1:0]  xPeakIdx,
   output logic [YI_W-1:0]  yPeakIdx,
   output logic [BIN_W-1:0] xPeakVal,
   output logic [BIN_W-1:0] yPeakVal
`endif
);

   localparam logic [XI_W-1:0]  X_LAST  = XI_W'(IMG_W - 1);
   localparam logic [YI_W-1:0]  Y_LAST  = YI_W'(IMG_H - 1);
   localparam logic [IDX_W-1:0] IX_LAST = IDX_W'(IMG_W - 1);
   localparam logic [IDX_W-1:0] IY_LAST = IDX_W'(IMG_H - 1);

   state_t           state, state_nxt;
   logic [XI_W-1:0]  x_pos;
   logic [YI_W-1:0]  y_pos;
   logic [BIN_W-1:0] col_acc;
   logic [BIN_W-1:0] col_sum;
   logic [TOT_W-1:0] total;
   logic [IDX_W-1:0] rd_idx;
   logic             finish_pend;
   logic             pix_take, col_end, last_pix;
   logic [BIN_W-1:0] x_rd, y_rd;
   logic [YI_W-1:0]  y_rd_addr;

   // A restart in the same cycle as a pixel discards that pixel.
   assign pix_take = (state == ST_ACCUM) && pixValid && !frameStart;
   assign col_end  = pix_take && (y_pos == Y_LAST);
   assign last_pix = col_end && (x_pos == X_LAST);
   assign col_sum  = BIN_W'(sat_add(32'(col_acc), 32'(pixData), BIN_W));

`ifdef PROJ_HIST_PEAK_EN
   // Peak tracking needs the current y bin while accumulating.
   assign y_rd_addr = (state == ST_ACCUM) ? y_pos : rd_idx[YI_W-1:0];
`else
   assign y_rd_addr = rd_idx[YI_W-1:0];
`endif

   proj_bin_array #(.DEPTH(IMG_W), .BIN_W(BIN_W), .AW(XI_W)) u_x_bins (
      .clk     (clk),
      .reset   (reset),
      .clr     (frameStart),
      .wr_en   (col_end),
      .inc_en  (1'b0),
      .inc_val (1'b0),
      .addr    (x_pos),
      .wr_data (col_sum),
      .rd_addr (rd_idx[XI_W-1:0]),
      .rd_data (x_rd)
   );

   proj_bin_array #(.DEPTH(IMG_H), .BIN_W(BIN_W), .AW(YI_W)) u_y_bins (
      .clk     (clk),
      .reset   (reset),
      .clr     (frameStart),
      .wr_en   (1'b0),
      .inc_en  (pix_take),
      .inc_val (pixData),
      .addr    (y_pos),
      .wr_data ('0),
      .rd_addr (y_rd_addr),
      .rd_data (y_rd)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state and readout outputs; frameStart overrides every state.
   always_comb begin
      state_nxt = state;
      xValid    = (state == ST_READ_X);
      yValid    = (state == ST_READ_Y);
      busy      = (state == ST_ACCUM) || (state == ST_READ_X) || (state == ST_READ_Y);
      binOut    = '0;
      binIndex  = '0;
      if (xValid) begin
         binOut   = x_rd;
         binIndex = rd_idx;
      end else if (yValid) begin
         binOut   = y_rd;
         binIndex = rd_idx;
      end
      if (frameStart) begin
         state_nxt = ST_ACCUM;
      end else begin
         case (state)
            ST_ACCUM:  if (last_pix) state_nxt = ST_DONE;
            ST_DONE:   if (readStart) state_nxt = ST_READ_X;
            ST_READ_X: if (readReady && (rd_idx == IX_LAST)) state_nxt = ST_READ_Y;
            ST_READ_Y: if (readReady && (rd_idx == IY_LAST)) state_nxt = ST_DONE;
            default:   state_nxt = state;
         endcase
      end
   end

   // Position counters, total, frame-end pulse/wake and readout index.
   always_ff @(posedge clk) begin
      if (!reset) begin
         x_pos         <= '0;
         y_pos         <= '0;
         col_acc       <= '0;
         total         <= '0;
         rd_idx        <= '0;
         finish_pend   <= 1'b0;
         fullImageDone <= 1'b0;
         wakeUp        <= 1'b0;
      end else begin
         fullImageDone <= finish_pend;
         finish_pend   <= last_pix;
         if (finish_pend) wakeUp <= (total >= threshold);
         if (frameStart) begin
            x_pos   <= '0;
            y_pos   <= '0;
            col_acc <= '0;
            total   <= '0;
         end else if (pix_take) begin
            total <= TOT_W'(sat_add(32'(total), 32'(pixData), TOT_W));
            if (y_pos == Y_LAST) begin
               y_pos   <= '0;
               col_acc <= '0;
               x_pos   <= (x_pos == X_LAST) ? '0 : x_pos + XI_W'(1);
            end else begin
               y_pos   <= y_pos + YI_W'(1);
               col_acc <= col_sum;
            end
         end
         if (state_nxt != state) begin
            rd_idx <= '0;
         end else if (((state == ST_READ_X) || (state == ST_READ_Y)) && readReady) begin
            rd_idx <= rd_idx + IDX_W'(1);
         end
      end
   end

`ifdef PROJ_HIST_PEAK_EN
   logic [BIN_W-1:0] y_new;
   assign y_new = BIN_W'(sat_add(32'(y_rd), 32'(pixData), BIN_W));

   // Argmax tracking; ties resolve to the lowest index.
   always_ff @(posedge clk) begin
      if (!reset || frameStart) begin
         xPeakIdx <= '0;
         yPeakIdx <= '0;
         xPeakVal <= '0;
         yPeakVal <= '0;
      end else if (pix_take) begin
         if ((y_new > yPeakVal) || ((y_new == yPeakVal) && (y_pos < yPeakIdx))) begin
            yPeakVal <= y_new;
            yPeakIdx <= y_pos;
         end
         if (col_end && (col_sum > xPeakVal)) begin
            xPeakVal <= col_sum;
            xPeakIdx <= x_pos;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/projection_histogram.md
Name: projection_histogram

Overview:
- Parametrised successor to the fixed 240x180 histogram stage.
- Accumulates column (x) and row (y) projection histograms of a binary image streamed in column-major order (y fastest) from the median-filter output.
- Compares total foreground count against a runtime threshold to raise `wakeUp`.
- Streams both histograms out through a valid/ready handshake.
- Generalised in image size, bin width and saturation; adds frame restart and backpressured readout.

Parameters:
- IMG_W, 240, image width in columns; x bins count.
- IMG_H, 180, image height in rows; y bins count.
- BIN_W, 8, output bin width; bins saturate at 2^BIN_W-1.
- TOT_W, 16, width of total foreground counter and threshold; total saturates.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- frameStart  in  1  pulse; clears bins and counters, enters ACCUM.
- pixValid  in  1  pixel strobe.
- pixData  in  1  binary pixel (1 = foreground).
- threshold  in  TOT_W  wake threshold, sampled at frame end.
- readStart  in  1  pulse; begins readout from DONE.
- readReady  in  1  consumer ready.
- wakeUp  out  1  level; total >= threshold for the last completed frame.
- fullImageDone  out  1  one-cycle pulse at frame completion.
- xValid  out  1  `binOut` carries an x bin.
- yValid  out  1  `binOut` carries a y bin.
- binOut  out  BIN_W  bin value.
- binIndex  out  clog2(max(IMG_W,IMG_H))  bin index.
- busy  out  1  high in ACCUM, READ_X and READ_Y.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE; all bins, counters and the total are cleared.
  - All outputs are 0.
- States: IDLE, ACCUM, DONE, READ_X, READ_Y.
- IDLE/DONE -> ACCUM on `frameStart`. In the same edge:
  - all bins cleared;
  - x/y position counters set to 0;
  - total set to 0;
  - `wakeUp` retained until the next frame end.
- ACCUM:
  - Each `pixValid` cycle adds `pixData` to:
    - the column accumulator colAcc;
    - yBin[y];
    - total.
  - y increments on each valid pixel.
  - At y = IMG_H-1: xBin[x] <= sat(colAcc + pixData), colAcc cleared, y wraps to 0, x increments.
  - The final pixel (x = IMG_W-1, y = IMG_H-1) moves the FSM to DONE. On the following cycle:
    - `fullImageDone` pulses for 1 cycle;
    - `wakeUp` <= (total >= threshold).
- Arithmetic: every add saturates at its field maximum and never wraps.
- `frameStart` during ACCUM aborts the frame and restarts clean. No `fullImageDone` is produced and `wakeUp` is unchanged.
- `frameStart` in the same cycle as the final pixel: restart wins, frame discarded.
- `pixValid` outside ACCUM is ignored.
- DONE -> READ_X on `readStart`. `readStart` in any other state is ignored.
- READ_X:
  - Presents xBin[0..IMG_W-1] with `xValid`=1 and `binIndex` = index.
  - Index advances only when `readReady` is high (AXIS-style). Outputs stay stable while stalled.
  - After index IMG_W-1 is accepted, moves to READ_Y with index 0.
- READ_Y: same as READ_X for yBin[0..IMG_H-1], then returns to DONE (bins preserved for re-read).
- `frameStart` during READ_X/READ_Y aborts readout: valids drop the next cycle and the FSM enters ACCUM.
- Latency: the first readout bin is valid 1 cycle after `readStart`. There is one bin per cycle at full throughput.

Optional Feature:
- Macro: PROJ_HIST_PEAK_EN.
- Defined:
  - Adds outputs xPeakIdx and yPeakIdx, plus xPeakVal and yPeakVal (BIN_W each).
  - These track the argmax bin during ACCUM, updated on each bin write. x is judged on the column commit; y is compared after each increment.
  - Ties keep the lowest index.
  - Valid from the `fullImageDone` pulse onward; cleared on `frameStart` and reset.
- Undefined: these ports and logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package projection_hist_pkg:
  - state enum;
  - localparam width helpers (XI_W = clog2(IMG_W), YI_W = clog2(IMG_H), IDX_W);
  - saturating-add function.
- Sub-module proj_bin_array (params DEPTH, BIN_W):
  - synchronous clear;
  - saturating increment/write at address;
  - combinational read port.
- Two instances: x and y arrays.

Test Plan:
- IMG_W=4, IMG_H=3, all-ones frame, threshold=12:
  - xBins = 3,3,3,3; yBins = 4,4,4;
  - `fullImageDone` single pulse;
  - `wakeUp`=1.
  - Same frame with threshold=13 -> `wakeUp`=0.
- Pixel order 1,0,0 / 0,1,0 / 0,0,1 / 1,1,1 (columns), readStart with readReady=1:
  - xValid for indices 0..3 with 1,1,1,3;
  - then yValid for 0..2 with 2,2,2;
  - return to DONE after 7 beats.
- BIN_W=2, IMG_H=5 all ones -> xBins saturate at 3, not wrap to 1. Total counts 5 per column.
- Readout with readReady toggled 1,0,0,1 -> `binOut`/`binIndex` held stable over stall cycles; no bin skipped or duplicated.
- `frameStart` after 7 of 12 pixels, then a full zero frame -> bins all 0; `fullImageDone` only once; `wakeUp`=0.
- reset=0 mid-READ_X -> next cycle all outputs 0, state IDLE. `readStart` is then ignored until a frame completes.
